// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if: decoder/VPU handshake bundle between the pipeline and the stall controller
interface stall_ctrl_if #(
    parameter int TIMER_W = 11,
    parameter int NUM_VPU = 2,
    parameter int MAX_OUT = 4
);
    localparam int SEL_W = NUM_VPU > 1 ? $clog2(NUM_VPU) : 1;
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    logic               issue_valid;
    logic               is_wait;
    logic               is_vpu;
    logic               is_sync;
    logic               is_halt;
    logic [TIMER_W-1:0] wait_time;
    logic [SEL_W-1:0]   vpu_sel;
    logic [NUM_VPU-1:0] vpu_rdy;
    logic [NUM_VPU-1:0] vpu_done;
    logic               resume;
    logic               stall;
    logic [NUM_VPU-1:0] vpu_start;
    logic [OUT_W-1:0]   outstanding;
    logic               halted;
    logic               err;
    modport master (
        output issue_valid, is_wait, is_vpu, is_sync, is_halt, wait_time, vpu_sel,
               vpu_rdy, vpu_done, resume,
        input  stall, vpu_start, outstanding, halted, err
    );
    modport slave (
        input  issue_valid, is_wait, is_vpu, is_sync, is_halt, wait_time, vpu_sel,
               vpu_rdy, vpu_done, resume,
        output stall, vpu_start, outstanding, halted, err
    );
endinterface

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall controller for WAIT/VPU/SYNC/HALT instructions
module stall_ctrl #(
    parameter int TIMER_W = 11,
    parameter int NUM_VPU = 2,
    parameter int MAX_OUT = 4
) (
    input logic         clk,
    input logic         rst,
    stall_ctrl_if.slave bus
);
    localparam int SEL_W = NUM_VPU > 1 ? $clog2(NUM_VPU) : 1;
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int RDY_W = 1 << SEL_W;
    typedef enum logic [1:0] {S_RUN, S_WAIT, S_DRAIN, S_HALTED} state_t;
    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [NUM_VPU-1:0] start_q, start_d;
    logic               err_q, err_d, hpend_q, hpend_d;
    logic [RDY_W-1:0]   rdy_ext;
    logic               issue, do_halt, do_sync, do_vpu, do_wait, sel_ok, accept;
    int unsigned        done_cnt, net;

    // decode the winning instruction class and compute the net in-flight count
    always_comb begin
        rdy_ext = RDY_W'(bus.vpu_rdy);
        issue = bus.issue_valid && state_q == S_RUN;
        do_halt = issue && bus.is_halt;
        do_sync = issue && !bus.is_halt && bus.is_sync;
        do_vpu = issue && !bus.is_halt && !bus.is_sync && bus.is_vpu;
        do_wait = issue && !bus.is_halt && !bus.is_sync && !bus.is_vpu && bus.is_wait
                  && bus.wait_time != '0;
        sel_ok = {1'b0, bus.vpu_sel} < (SEL_W + 1)'(NUM_VPU);
        accept = do_vpu && sel_ok && rdy_ext[bus.vpu_sel] && out_q < OUT_W'(MAX_OUT);
        done_cnt = 0;
        for (int i = 0; i < NUM_VPU; i++) done_cnt = done_cnt + 32'(bus.vpu_done[i]);
        net = 32'(out_q) + 32'(accept);
        out_d = done_cnt > net ? '0 : OUT_W'(net - done_cnt);
        err_d = err_q || done_cnt > net || (do_vpu && !sel_ok);
        start_d = accept ? NUM_VPU'(1) << bus.vpu_sel : '0;
    end

    // next-state logic; a drain ends as soon as the net count lands on zero
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        hpend_d = hpend_q;
        case (state_q)
            S_RUN: begin
                if (do_halt) begin
                    state_d = out_q == '0 ? S_HALTED : S_DRAIN;
                    hpend_d = out_q != '0;
                end else if (do_sync && out_q != '0) begin
                    state_d = S_DRAIN;
                end else if (do_wait) begin
                    state_d = S_WAIT;
                    timer_d = bus.wait_time;
                end
            end
            S_WAIT: begin
                timer_d = timer_q - 1'b1;
                state_d = timer_q == TIMER_W'(1) ? S_RUN : S_WAIT;
            end
            S_DRAIN: begin
                if (out_d == '0) begin
                    state_d = hpend_q ? S_HALTED : S_RUN;
                    hpend_d = 1'b0;
                end
            end
            default: state_d = bus.resume ? S_RUN : S_HALTED;
        endcase
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            timer_q <= '0;
            out_q   <= '0;
            start_q <= '0;
            err_q   <= 1'b0;
            hpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            out_q   <= out_d;
            start_q <= start_d;
            err_q   <= err_d;
            hpend_q <= hpend_d;
        end
    end

    assign bus.stall       = !rst && (state_q != S_RUN || (do_vpu && sel_ok && !accept));
    assign bus.vpu_start   = start_q;
    assign bus.outstanding = out_q;
    assign bus.halted      = state_q == S_HALTED;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: table-driven directed checks for stall_ctrl
module tb_stall_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stall_ctrl_if #(.TIMER_W(11), .NUM_VPU(2), .MAX_OUT(4)) bus ();
    stall_ctrl_if #(.TIMER_W(11), .NUM_VPU(3), .MAX_OUT(4)) bus3 ();
    stall_ctrl #(.TIMER_W(11), .NUM_VPU(2), .MAX_OUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    stall_ctrl #(.TIMER_W(11), .NUM_VPU(3), .MAX_OUT(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct {
        logic       iv, w, v, s, h;
        int         wt, sel;
        logic [1:0] rdy, done;
        logic       res, e_stall;
        logic [1:0] e_start;
        int         e_out;
        logic       e_halt, e_err;
    } vec_t;
    vec_t tbl[$];
    int passed = 0;
    int total = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic add(input logic iv, w, v, s, h, input int wt, sel,
                       input logic [1:0] rdy, done, input logic res, es,
                       input logic [1:0] est, input int eo, input logic eh, ee);
        vec_t r;
        r = '{iv, w, v, s, h, wt, sel, rdy, done, res, es, est, eo, eh, ee};
        tbl.push_back(r);
    endtask

    task automatic drive(input vec_t r);
        bus.issue_valid = r.iv;
        bus.is_wait = r.w;
        bus.is_vpu = r.v;
        bus.is_sync = r.s;
        bus.is_halt = r.h;
        bus.wait_time = 11'(r.wt);
        bus.vpu_sel = 1'(r.sel);
        bus.vpu_rdy = r.rdy;
        bus.vpu_done = r.done;
        bus.resume = r.res;
    endtask

    task automatic idle3();
        bus3.issue_valid = 0; bus3.is_wait = 0; bus3.is_vpu = 0; bus3.is_sync = 0;
        bus3.is_halt = 0; bus3.wait_time = '0; bus3.vpu_sel = '0; bus3.vpu_rdy = 3'b111;
        bus3.vpu_done = '0; bus3.resume = 0;
    endtask

    task automatic idle();
        vec_t r;
        r = '{0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 0};
        drive(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // wait 5: exactly five stall cycles after the issue cycle; wait 0 is a nop
        add(1,1,0,0,0, 5,0,2'b11,2'b00,0, 0,2'b00,0,0,0);
        for (int i = 0; i < 5; i++) add(0,0,0,0,0, 0,0,2'b11,2'b00,0, 1,2'b00,0,0,0);
        add(0,0,0,0,0, 0,0,2'b11,2'b00,0, 0,2'b00,0,0,0);
        add(1,1,0,0,0, 0,0,2'b11,2'b00,0, 0,2'b00,0,0,0);
        add(0,0,0,0,0, 0,0,2'b11,2'b00,0, 0,2'b00,0,0,0);
        // channel 1 not ready for three cycles, then accepted
        for (int i = 0; i < 3; i++) add(1,0,1,0,0, 0,1,2'b01,2'b00,0, 1,2'b00,0,0,0);
        add(1,0,1,0,0, 0,1,2'b11,2'b00,0, 0,2'b10,1,0,0);
        add(0,0,0,0,0, 0,0,2'b11,2'b00,0, 0,2'b00,1,0,0);
        // fill to MAX_OUT, fifth op stalls until a done frees a slot
        for (int i = 2; i <= 4; i++) add(1,0,1,0,0, 0,0,2'b11,2'b00,0, 0,2'b01,i,0,0);
        add(1,0,1,0,0, 0,0,2'b11,2'b00,0, 1,2'b00,4,0,0);
        add(1,0,1,0,0, 0,0,2'b11,2'b01,0, 1,2'b00,3,0,0);
        add(1,0,1,0,0, 0,0,2'b11,2'b00,0, 0,2'b01,4,0,0);
        add(0,0,0,0,0, 0,0,2'b11,2'b01,0, 0,2'b00,3,0,0);
        add(1,0,1,0,0, 0,1,2'b11,2'b01,0, 0,2'b10,3,0,0);
        // halt with two in flight drains, halts, then resumes
        add(0,0,0,0,0, 0,0,2'b11,2'b01,0, 0,2'b00,2,0,0);
        add(1,0,0,0,1, 0,0,2'b11,2'b00,0, 0,2'b00,2,0,0);
        add(0,0,0,0,0, 0,0,2'b11,2'b00,0, 1,2'b00,2,0,0);
        add(0,0,0,0,0, 0,0,2'b11,2'b01,0, 1,2'b00,1,0,0);
        add(0,0,0,0,0, 0,0,2'b11,2'b10,0, 1,2'b00,0,1,0);
        add(0,0,0,0,0, 0,0,2'b11,2'b00,0, 1,2'b00,0,1,0);
        add(1,0,1,0,0, 0,0,2'b11,2'b00,0, 1,2'b00,0,1,0);
        add(0,0,0,0,0, 0,0,2'b11,2'b00,1, 1,2'b00,0,0,0);
        add(0,0,0,0,0, 0,0,2'b11,2'b00,0, 0,2'b00,0,0,0);
        // underflowing done sets sticky err
        add(0,0,0,0,0, 0,0,2'b11,2'b01,0, 0,2'b00,0,0,1);
        add(0,0,0,0,0, 0,0,2'b11,2'b00,0, 0,2'b00,0,0,1);
        // sync with one in flight drains back to RUN
        add(1,0,1,0,0, 0,0,2'b11,2'b00,0, 0,2'b01,1,0,1);
        add(1,0,0,1,0, 0,0,2'b11,2'b00,0, 0,2'b00,1,0,1);
        add(0,0,0,0,0, 0,0,2'b11,2'b00,0, 1,2'b00,1,0,1);
        add(0,0,0,0,0, 0,0,2'b11,2'b01,0, 1,2'b00,0,0,1);
        add(0,0,0,0,0, 0,0,2'b11,2'b00,0, 0,2'b00,0,0,1);
        // halt wins over vpu and wait; class bits ignored without issue_valid
        add(1,1,1,0,1, 5,0,2'b11,2'b00,0, 0,2'b00,0,1,1);
        add(0,0,0,0,0, 0,0,2'b11,2'b00,1, 1,2'b00,0,0,1);
        add(0,0,0,0,0, 0,0,2'b11,2'b00,0, 0,2'b00,0,0,1);
        add(0,1,1,0,1, 3,0,2'b11,2'b00,0, 0,2'b00,0,0,1);
        add(0,0,0,0,0, 0,0,2'b11,2'b00,0, 0,2'b00,0,0,1);

        idle();
        idle3();
        rst = 1'b1;
        tick();
        bus.issue_valid = 1; bus.is_wait = 1; bus.wait_time = 11'd3; bus.vpu_done = 2'b01;
        #1;
        chk("rst stall", int'(bus.stall), 0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("post-rst stall", int'(bus.stall), 0);
        chk("post-rst out", int'(bus.outstanding), 0);
        chk("post-rst err", int'(bus.err), 0);
        chk("post-rst halted", int'(bus.halted), 0);
        chk("post-rst start", int'(bus.vpu_start), 0);
        tick();

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d stall", i), int'(bus.stall), int'(tbl[i].e_stall));
            tick();
            chk($sformatf("v%0d start", i), int'(bus.vpu_start), int'(tbl[i].e_start));
            chk($sformatf("v%0d out", i), int'(bus.outstanding), tbl[i].e_out);
            chk($sformatf("v%0d halted", i), int'(bus.halted), int'(tbl[i].e_halt));
            chk($sformatf("v%0d err", i), int'(bus.err), int'(tbl[i].e_err));
        end

        idle();
        bus.issue_valid = 1; bus.is_vpu = 1;
        tick();
        chk("mw out", int'(bus.outstanding), 1);
        idle();
        bus.issue_valid = 1; bus.is_wait = 1; bus.wait_time = 11'd10;
        #1;
        chk("mw issue stall", int'(bus.stall), 0);
        tick();
        idle();
        #1;
        chk("mw c1 stall", int'(bus.stall), 1);
        tick();
        #1;
        chk("mw c2 stall", int'(bus.stall), 1);
        tick();
        rst = 1'b1;
        #1;
        chk("mw rst stall", int'(bus.stall), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mw after stall", int'(bus.stall), 0);
        chk("mw after out", int'(bus.outstanding), 0);
        chk("mw after err", int'(bus.err), 0);
        chk("mw after halted", int'(bus.halted), 0);
        chk("mw after start", int'(bus.vpu_start), 0);
        tick();
        #1;
        chk("mw run stall", int'(bus.stall), 0);

        bus3.issue_valid = 1; bus3.is_vpu = 1; bus3.vpu_sel = 2'd3;
        #1;
        chk("sel3 stall", int'(bus3.stall), 0);
        tick();
        chk("sel3 err", int'(bus3.err), 1);
        chk("sel3 start", int'(bus3.vpu_start), 0);
        chk("sel3 out", int'(bus3.outstanding), 0);
        bus3.vpu_sel = 2'd2;
        tick();
        chk("sel2 start", int'(bus3.vpu_start), 4);
        chk("sel2 out", int'(bus3.outstanding), 1);
        idle3();
        tick();
        chk("sel2 pulse end", int'(bus3.vpu_start), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
